axi_master_arbiter: RTL and testbench
=====================================

Name: axi_master_arbiter

Overview:
- Shares one AXI master front-end (read channel and write channel controllers) between two CPU-side requesters: requester 0 is instruction fetch (read only), requester 1 is the data port (read or write).
- Latches one request at a time, drives a single-cycle-qualified command to the master, and waits for completion.
- Returns read data or write completion to the owner, then re-arbitrates using round-robin.
- Guarantees read and write transactions never overlap, so the master controllers need no cross-interlock.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- ID_W, 4, AXI ID width; requester n issues ID = n
- TMO_W, 8, width of the completion timeout counter; timeout fires at 2^TMO_W-1 cycles

Ports:
- ACLK  in  1  clock
- ARESET  in  1  asynchronous active-high reset
- req0_valid  in  1  instruction fetch request, level, held until done0
- req0_addr  in  ADDR_W  fetch address
- req1_valid  in  1  data request, level, held until done1
- req1_write  in  1  1 = write, 0 = read
- req1_addr  in  ADDR_W  data address
- req1_wdata  in  DATA_W  write data
- req1_wstrb  in  DATA_W/8  byte strobes; all-zero treated as read
- m_rd_req  out  1  read command valid to the read controller
- m_wr_req  out  1  write command valid to the write controller
- m_addr  out  ADDR_W  command address
- m_wdata  out  DATA_W  write data
- m_wstrb  out  DATA_W/8  write strobes
- m_id  out  ID_W  transaction ID
- m_ack  in  1  command accepted (AW/AR handshake done)
- m_done  in  1  one-cycle completion pulse (RLAST beat or B handshake)
- m_rdata  in  DATA_W  read data, valid with m_done
- m_err  in  1  non-OKAY RRESP/BRESP, valid with m_done
- stall0  out  1  high while req0_valid and not done0
- stall1  out  1  high while req1_valid and not done1
- done0, done1  out  1  one-cycle completion pulse to the owner
- rdata  out  DATA_W  registered read data, valid with done
- err  out  1  valid with done; set on m_err or timeout
- busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; last_gnt = 1, so requester 0 wins first; counter 0. ARESET mid-transaction aborts immediately. No done pulse is issued for the aborted transaction.
- States:
  - IDLE: pick a requester (arbitration below); on a pick, latch addr, wdata, wstrb, write flag and owner into registers, then go to ISSUE next cycle.
  - ISSUE: m_rd_req or m_wr_req = 1 from the latched type; m_addr, m_wdata, m_wstrb and m_id come from the latched registers and are held stable. On m_ack, go to WAIT.
  - WAIT: command outputs = 0; wait for m_done, then go to RESP.
  - RESP: for one cycle, done<owner> = 1, rdata = latched m_rdata (0 for writes), err = latched error. Update last_gnt = owner. Go to IDLE.
- Arbitration, evaluated in IDLE only:
  - Only one valid: that requester wins.
  - Both valid: the requester that is not last_gnt wins.
  - A request that rises during ISSUE, WAIT or RESP waits for IDLE.
- Latency: req seen in IDLE, command on the next cycle. Best case with m_ack in the same cycle and m_done one cycle later: done pulses 3 cycles after request.
- stall<n> is combinational: req<n>_valid & ~done<n>. It drops in the RESP cycle so the CPU advances exactly once. The requester must deassert or change its request on the cycle after done.
- Timeout:
  - Counter clears on entering ISSUE and increments every cycle in ISSUE or WAIT.
  - At all-ones, go to RESP with err = 1 and rdata = 0.
  - A later stray m_done or m_ack in IDLE is ignored.
- Simultaneous m_ack and m_done in ISSUE: go directly to RESP; capture rdata and err that cycle.
- m_done outside WAIT/ISSUE: ignored.
- Read requests ignore wdata and wstrb; m_wstrb = 0 on reads.

Test Plan:
- Single fetch: req0 addr 0x0000_0100, m_ack in ISSUE cycle 1, m_done 2 cycles later with rdata 0xDEAD_BEEF -> m_rd_req 1 cycle, m_id 0, done0 pulse, rdata 0xDEAD_BEEF, stall0 drops in RESP cycle.
- Data write: req1 write addr 0x0001_0004, wdata 0x1234_5678, wstrb 0x3 -> m_wr_req, m_wstrb 0x3, m_id 1; m_done -> done1, rdata 0, err 0.
- Contention: req0 and req1 held continuously for 4 transactions -> grants alternate 0,1,0,1 after reset; never two commands outstanding.
- Command hold: m_ack delayed 5 cycles -> m_addr/m_wdata stable and m_rd_req held all 5 cycles.
- Timeout: m_ack given, m_done never returns -> done pulse with err = 1 after 255 cycles (TMO_W = 8); m_done injected afterwards in IDLE is ignored.
- Async reset asserted during WAIT -> outputs 0 immediately, no done pulse; next request after deassert is granted to requester 0.

Source files
------------

// File: rtl/axi_master_arbiter.sv
// Shares one AXI read/write command front-end between fetch (req0) and data (req1) requesters.
// Latency: command one cycle after a request is seen in IDLE; done pulses 3 cycles after request at best.
// Backpressure: one transaction at a time; requesters stall until their done pulse; command held until m_ack.
module axi_master_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int TMO_W  = 8
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                req0_valid,
    input  logic [ADDR_W-1:0]   req0_addr,
    input  logic                req1_valid,
    input  logic                req1_write,
    input  logic [ADDR_W-1:0]   req1_addr,
    input  logic [DATA_W-1:0]   req1_wdata,
    input  logic [DATA_W/8-1:0] req1_wstrb,
    output logic                m_rd_req,
    output logic                m_wr_req,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic [ID_W-1:0]     m_id,
    input  logic                m_ack,
    input  logic                m_done,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_err,
    output logic                stall0,
    output logic                stall1,
    output logic                done0,
    output logic                done1,
    output logic [DATA_W-1:0]   rdata,
    output logic                err,
    output logic                busy
);
    localparam int STRB_W = DATA_W / 8;
    // Last counter value still spent in ISSUE/WAIT; the counter reaches all-ones on entry to RESP.
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                write_q, write_d;
    logic                owner_q, owner_d;
    logic                last_gnt_q, last_gnt_d;
    logic [TMO_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                pick_vld;
    logic                pick_own;
    logic                req1_is_wr;

    // A data write with no strobes carries nothing to write, so it is issued as a read.
    assign req1_is_wr = req1_write & (|req1_wstrb);

    // Round-robin pick: a lone requester wins, on contention the one not served last wins.
    always_comb begin
        pick_vld = req0_valid | req1_valid;
        pick_own = req1_valid;
        if (req0_valid && req1_valid) begin
            pick_own = ~last_gnt_q;
        end
    end

    // State, latch and completion-capture registers; reset aborts any transaction in flight.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            write_q    <= 1'b0;
            owner_q    <= 1'b0;
            last_gnt_q <= 1'b1;
            cnt_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            write_q    <= write_d;
            owner_q    <= owner_d;
            last_gnt_q <= last_gnt_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    // Next-state: latch on grant, hold the command until accepted, capture completion or timeout.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        write_d    = write_q;
        owner_d    = owner_q;
        last_gnt_d = last_gnt_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    owner_d = pick_own;
                    cnt_d   = '0;
                    state_d = ST_ISSUE;
                    if (pick_own) begin
                        addr_d  = req1_addr;
                        write_d = req1_is_wr;
                        wdata_d = req1_is_wr ? req1_wdata : '0;
                        wstrb_d = req1_is_wr ? req1_wstrb : '0;
                    end else begin
                        addr_d  = req0_addr;
                        write_d = 1'b0;
                        wdata_d = '0;
                        wstrb_d = '0;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d = cnt_q + TMO_W'(1);
                if (m_ack && m_done) begin
                    rdata_d = write_q ? '0 : m_rdata;
                    err_d   = m_err;
                    state_d = ST_RESP;
                end else if (m_ack) begin
                    state_d = ST_WAIT;
                end else if (cnt_q == TMO_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + TMO_W'(1);
                if (m_done) begin
                    rdata_d = write_q ? '0 : m_rdata;
                    err_d   = m_err;
                    state_d = ST_RESP;
                end else if (cnt_q == TMO_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                last_gnt_d = owner_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Command outputs are only non-zero while the command is being offered.
    always_comb begin
        m_rd_req = 1'b0;
        m_wr_req = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        m_wstrb  = '0;
        m_id     = '0;
        if (state_q == ST_ISSUE) begin
            m_rd_req = ~write_q;
            m_wr_req = write_q;
            m_addr   = addr_q;
            m_wdata  = wdata_q;
            m_wstrb  = wstrb_q;
            m_id     = {{(ID_W-1){1'b0}}, owner_q};
        end
    end

    assign done0  = (state_q == ST_RESP) & ~owner_q;
    assign done1  = (state_q == ST_RESP) & owner_q;
    assign stall0 = req0_valid & ~done0;
    assign stall1 = req1_valid & ~done1;
    assign rdata  = rdata_q;
    assign err    = err_q;
    assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_axi_master_arbiter.sv
module tb_axi_master_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int TW = 8;
    localparam int SW = DW / 8;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic          req0_valid = 1'b0;
    logic [AW-1:0] req0_addr = '0;
    logic          req1_valid = 1'b0;
    logic          req1_write = 1'b0;
    logic [AW-1:0] req1_addr = '0;
    logic [DW-1:0] req1_wdata = '0;
    logic [SW-1:0] req1_wstrb = '0;
    logic          m_rd_req, m_wr_req;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [SW-1:0] m_wstrb;
    logic [IW-1:0] m_id;
    logic          m_ack = 1'b0;
    logic          m_done = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    logic          m_err = 1'b0;
    logic          stall0, stall1, done0, done1, err, busy;
    logic [DW-1:0] rdata;

    axi_master_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .TMO_W(TW)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .req0_valid(req0_valid), .req0_addr(req0_addr),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_wstrb(req1_wstrb),
        .m_rd_req(m_rd_req), .m_wr_req(m_wr_req), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_id(m_id), .m_ack(m_ack), .m_done(m_done),
        .m_rdata(m_rdata), .m_err(m_err),
        .stall0(stall0), .stall1(stall1), .done0(done0), .done1(done1),
        .rdata(rdata), .err(err), .busy(busy)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
        logic [IW-1:0] id;
    } cmd_t;

    typedef struct {
        logic          owner;
        logic [DW-1:0] rdata;
        logic          err;
        int            lat;
    } rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                              input logic [SW-1:0] wstrb, input logic owner, input logic [DW-1:0] rd,
                              input logic e, input int lat);
        cmd_t c;
        rsp_t r;
        c.wr = wr; c.addr = addr; c.wdata = wdata; c.wstrb = wstrb;
        c.id = {{(IW-1){1'b0}}, owner};
        r.owner = owner; r.rdata = rd; r.err = e; r.lat = lat;
        cmd_q.push_back(c);
        rsp_q.push_back(r);
    endtask

    // Acts as the master controllers for one transaction and scores the command and the response.
    task automatic serve(input int ack_dly, input int done_dly, input logic [DW-1:0] rd, input logic e,
                         input bit tmo, input bit scramble);
        cmd_t c;
        rsp_t r;
        int   n;
        int   c0;
        n = 0;
        while (!(m_rd_req | m_wr_req) && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        check("cmd_seen", m_rd_req | m_wr_req, 1);
        check("sb_nonempty", (cmd_q.size() > 0) && (rsp_q.size() > 0), 1);
        if (cmd_q.size() == 0 || rsp_q.size() == 0) return;
        c  = cmd_q.pop_front();
        r  = rsp_q.pop_front();
        c0 = cyc;
        check("cmd_rd", m_rd_req, !c.wr);
        check("cmd_wr", m_wr_req, c.wr);
        check("cmd_addr", m_addr, c.addr);
        check("cmd_id", m_id, c.id);
        check("cmd_wstrb", m_wstrb, c.wstrb);
        if (c.wr) check("cmd_wdata", m_wdata, c.wdata);
        check("stall_owner_pending", r.owner ? stall1 : stall0, 1);
        for (int i = 0; i < ack_dly; i++) begin
            if (scramble) begin
                req0_addr  = $urandom;
                req1_addr  = $urandom;
                req1_wdata = $urandom;
            end
            @(negedge ACLK);
            check("hold_req", c.wr ? m_wr_req : m_rd_req, 1);
            check("hold_addr", m_addr, c.addr);
            check("hold_id", m_id, c.id);
            if (c.wr) check("hold_wdata", m_wdata, c.wdata);
        end
        m_ack = 1'b1;
        if (done_dly == 0 && !tmo) begin
            m_done = 1'b1; m_rdata = rd; m_err = e;
        end
        @(negedge ACLK);
        m_ack = 1'b0; m_done = 1'b0; m_rdata = '0; m_err = 1'b0;
        check("single_cmd", m_rd_req | m_wr_req, 0);
        if (!tmo && done_dly > 0) begin
            repeat (done_dly - 1) @(negedge ACLK);
            m_done = 1'b1; m_rdata = rd; m_err = e;
            @(negedge ACLK);
            m_done = 1'b0; m_rdata = '0; m_err = 1'b0;
        end
        n = 0;
        while (!(done0 | done1) && n < 400) begin
            @(negedge ACLK);
            n++;
        end
        check("done_seen", done0 | done1, 1);
        check("done0", done0, !r.owner);
        check("done1", done1, r.owner);
        check("rdata", rdata, r.rdata);
        check("err", err, r.err);
        check("latency", cyc - c0, r.lat);
        check("stall_owner_drop", r.owner ? stall1 : stall0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int   tr;
        logic saw;

        // Reset state
        ARESET = 1'b0;
        #1 ARESET = 1'b1;
        #1;
        check("rst_rd_req", m_rd_req, 0);
        check("rst_wr_req", m_wr_req, 0);
        check("rst_addr", m_addr, 0);
        check("rst_id", m_id, 0);
        check("rst_done", {done0, done1}, 0);
        check("rst_rdata", rdata, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_stall", {stall0, stall1}, 0);
        repeat (2) @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);

        // Single fetch: command next cycle, done two cycles after acceptance
        expect_txn(1'b0, 32'h0000_0100, '0, '0, 1'b0, 32'hDEAD_BEEF, 1'b0, 3);
        req0_valid = 1'b1; req0_addr = 32'h0000_0100;
        @(negedge ACLK);
        check("fetch_cmd_next_cycle", m_rd_req, 1);
        serve(0, 2, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        req0_valid = 1'b0;
        @(negedge ACLK);

        // Data write at best-case latency; write returns rdata 0 whatever m_rdata carries
        expect_txn(1'b1, 32'h0001_0004, 32'h1234_5678, 4'h3, 1'b1, '0, 1'b0, 2);
        req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 32'h0001_0004;
        req1_wdata = 32'h1234_5678; req1_wstrb = 4'h3;
        tr = cyc;
        serve(0, 1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        check("best_case_req_to_done", cyc - tr, 3);
        req1_valid = 1'b0;
        @(negedge ACLK);

        // Write with no strobes goes out as a read; ack and done together, error reported
        expect_txn(1'b0, 32'h0002_0000, '0, '0, 1'b1, 32'hA5A5_0001, 1'b1, 1);
        req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 32'h0002_0000;
        req1_wdata = 32'h7777_7777; req1_wstrb = 4'h0;
        serve(0, 0, 32'hA5A5_0001, 1'b1, 1'b0, 1'b0);
        req1_valid = 1'b0;
        @(negedge ACLK);

        // Contention: both held, grants alternate 0,1,0,1
        req0_valid = 1'b1; req0_addr = 32'h0000_0200;
        req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 32'h0000_3000;
        req1_wdata = 32'hCAFE_0000; req1_wstrb = 4'hF;
        expect_txn(1'b0, 32'h0000_0200, '0, '0, 1'b0, 32'h1111_0000, 1'b0, 3);
        expect_txn(1'b1, 32'h0000_3000, 32'hCAFE_0000, 4'hF, 1'b1, '0, 1'b1, 3);
        expect_txn(1'b0, 32'h0000_0200, '0, '0, 1'b0, 32'h3333_0000, 1'b0, 3);
        expect_txn(1'b1, 32'h0000_3000, 32'hCAFE_0000, 4'hF, 1'b1, '0, 1'b0, 2);
        serve(1, 1, 32'h1111_0000, 1'b0, 1'b0, 1'b0);
        serve(0, 2, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        serve(2, 0, 32'h3333_0000, 1'b0, 1'b0, 1'b0);
        serve(0, 1, 32'h0BAD_0BAD, 1'b0, 1'b0, 1'b0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge ACLK);

        // Command hold: acceptance delayed 5 cycles while requester inputs churn
        expect_txn(1'b0, 32'h0000_0400, '0, '0, 1'b0, 32'h4444_0000, 1'b0, 7);
        req0_valid = 1'b1; req0_addr = 32'h0000_0400;
        serve(5, 1, 32'h4444_0000, 1'b0, 1'b0, 1'b1);
        req0_valid = 1'b0;
        @(negedge ACLK);
        expect_txn(1'b1, 32'h0000_9000, 32'h55AA_55AA, 4'hC, 1'b1, '0, 1'b0, 5);
        req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 32'h0000_9000;
        req1_wdata = 32'h55AA_55AA; req1_wstrb = 4'hC;
        serve(3, 1, 32'h1234_0000, 1'b0, 1'b0, 1'b1);
        req1_valid = 1'b0;
        @(negedge ACLK);

        // Timeout: accepted but never completed
        expect_txn(1'b0, 32'h0000_0500, '0, '0, 1'b0, '0, 1'b1, 255);
        req0_valid = 1'b1; req0_addr = 32'h0000_0500;
        serve(0, 0, '0, 1'b0, 1'b1, 1'b0);
        req0_valid = 1'b0;
        @(negedge ACLK);
        // Stray completion and acceptance in IDLE must be ignored
        saw = 1'b0;
        m_done = 1'b1; m_ack = 1'b1; m_rdata = 32'hFFFF_FFFF; m_err = 1'b1;
        repeat (3) begin
            @(negedge ACLK);
            saw = saw | done0 | done1 | busy;
        end
        m_done = 1'b0; m_ack = 1'b0; m_rdata = '0; m_err = 1'b0;
        @(negedge ACLK);
        saw = saw | done0 | done1 | busy;
        check("stray_done_ignored", saw, 0);

        // Async reset during WAIT aborts without a done pulse
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 32'h0000_0600; req1_wstrb = '0;
        @(negedge ACLK);
        check("abort_cmd", m_rd_req, 1);
        m_ack = 1'b1;
        @(negedge ACLK);
        m_ack = 1'b0;
        check("abort_in_wait", busy, 1);
        #2 ARESET = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_rd_req", m_rd_req, 0);
        check("abort_addr", m_addr, 0);
        check("abort_done", {done0, done1}, 0);
        check("abort_rdata", rdata, 0);
        check("abort_err", err, 0);
        req1_valid = 1'b0;
        saw = 1'b0;
        repeat (3) begin
            @(negedge ACLK);
            saw = saw | done0 | done1;
        end
        ARESET = 1'b0;
        repeat (2) begin
            @(negedge ACLK);
            saw = saw | done0 | done1;
        end
        check("abort_no_done", saw, 0);

        // After reset requester 0 wins a contended first grant
        expect_txn(1'b0, 32'h0000_0700, '0, '0, 1'b0, 32'h7070_7070, 1'b0, 2);
        expect_txn(1'b0, 32'h0000_0800, '0, '0, 1'b1, 32'h8080_8080, 1'b0, 2);
        req0_valid = 1'b1; req0_addr = 32'h0000_0700;
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 32'h0000_0800;
        serve(0, 1, 32'h7070_7070, 1'b0, 1'b0, 1'b0);
        req0_valid = 1'b0;
        serve(0, 1, 32'h8080_8080, 1'b0, 1'b0, 1'b0);
        req1_valid = 1'b0;
        repeat (2) @(negedge ACLK);
        check("sb_drained", cmd_q.size() + rsp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
